// File: rtl/riscv_mem_pkg.sv
// Shared definitions for the memory stage of the pipelined RISC-V core.
// Holds the load/store size encodings (func3), the memory-stage FSM state
// encoding, the default bus timeout, and a helper that decides whether a
// request is legal (size valid for the direction and naturally aligned).
package riscv_mem_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } memState_t;

  // Unsigned sizes exist only for loads; halves must sit on even bytes and
  // words on word boundaries.
  function automatic logic accessLegal(input logic [2:0] f3,
                                       input logic [1:0] lane,
                                       input logic       isStore);
    logic ok;
    case (f3)
      F3_B:    ok = 1'b1;
      F3_H:    ok = ~lane[0];
      F3_W:    ok = (lane == 2'b00);
      F3_BU:   ok = ~isStore;
      F3_HU:   ok = ~isStore & ~lane[0];
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/load_store_aligner.sv
// Purely combinational lane steering for the memory stage.
// Store side: replicates the store source across the bus word and produces
// the byte enables for the addressed lanes.
// Load side: picks the addressed byte/half out of the raw read word and
// sign- or zero-extends it.
// Ports:
//   i_storeFunc3, i_storeLane, i_storeData  -> o_writeData, o_byteEnable
//   i_loadFunc3,  i_loadLane,  i_readWord   -> o_loadData
module load_store_aligner
  import riscv_mem_pkg::*;
(
  input  logic [2:0]  i_storeFunc3,
  input  logic [1:0]  i_storeLane,
  input  logic [31:0] i_storeData,
  output logic [31:0] o_writeData,
  output logic [3:0]  o_byteEnable,
  input  logic [2:0]  i_loadFunc3,
  input  logic [1:0]  i_loadLane,
  input  logic [31:0] i_readWord,
  output logic [31:0] o_loadData
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Memory picks the lanes with the byte enables, so replicating the data
  // lets every lane carry the right value without a shifter.
  always_comb begin
    o_writeData  = i_storeData;
    o_byteEnable = 4'b1111;
    case (i_storeFunc3)
      F3_B: begin
        o_writeData  = {4{i_storeData[7:0]}};
        o_byteEnable = 4'b0001 << i_storeLane;
      end
      F3_H: begin
        o_writeData  = {2{i_storeData[15:0]}};
        o_byteEnable = i_storeLane[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        o_writeData  = i_storeData;
        o_byteEnable = 4'b1111;
      end
    endcase
  end

  always_comb begin
    w_byte = i_readWord[7:0];
    case (i_loadLane)
      2'd0: w_byte = i_readWord[7:0];
      2'd1: w_byte = i_readWord[15:8];
      2'd2: w_byte = i_readWord[23:16];
      2'd3: w_byte = i_readWord[31:24];
      default: w_byte = i_readWord[7:0];
    endcase
    w_half = i_loadLane[1] ? i_readWord[31:16] : i_readWord[15:0];

    o_loadData = i_readWord;
    case (i_loadFunc3)
      F3_B:    o_loadData = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_loadData = {24'd0, w_byte};
      F3_H:    o_loadData = {{16{w_half[15]}}, w_half};
      F3_HU:   o_loadData = {16'd0, w_half};
      default: o_loadData = i_readWord;
    endcase
  end

endmodule

// File: rtl/memory_access_unit.sv
// Memory stage of the pipelined RISC-V core. Takes a load/store from EX/MEM,
// runs it on the data bus with a valid/ready handshake, freezes the upstream
// pipeline while the access is outstanding, and hands formatted load data to
// MEM/WB. Flags illegal/misaligned requests and bus timeouts.
// Ports:
//   clock, reset (async, active-low)
//   EX/MEM side : memoryReadEnable, memoryWriteEnable, address, storeData, func3
//   pipeline    : stall, loadData, loadValid, accessFault, busError
//   data bus    : busRequest, busWrite, busAddress, busWriteData,
//                 busByteEnable, busReady, busReadData
module memory_access_unit
  import riscv_mem_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        memoryReadEnable,
  input  logic        memoryWriteEnable,
  input  logic [31:0] address,
  input  logic [31:0] storeData,
  input  logic [2:0]  func3,
  output logic        stall,
  output logic [31:0] loadData,
  output logic        loadValid,
  output logic        accessFault,
  output logic        busError,
  output logic        busRequest,
  output logic        busWrite,
  output logic [31:0] busAddress,
  output logic [31:0] busWriteData,
  output logic [3:0]  busByteEnable,
  input  logic        busReady,
  input  logic [31:0] busReadData
);

  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  memState_t   r_state, w_nextState;
  logic [7:0]  r_waitCount;
  logic [2:0]  r_func3;
  logic [1:0]  r_lane;
  logic        r_busWrite;
  logic [31:0] r_busAddress;
  logic [31:0] r_busWriteData;
  logic [3:0]  r_busByteEnable;
  logic [31:0] r_loadData;
  logic        r_loadValid;
  logic        r_busError;

  logic        w_anyEnable;
  logic        w_legal;
  logic        w_start;
  logic        w_fsmStall;
  logic        w_fsmFault;
  logic        w_busRequest;
  logic        w_readyHit;
  logic        w_timeoutHit;
  logic [31:0] w_alignedWriteData;
  logic [3:0]  w_alignedByteEnable;
  logic [31:0] w_formattedLoad;

  assign w_anyEnable = memoryReadEnable | memoryWriteEnable;
  assign w_legal     = ~(memoryReadEnable & memoryWriteEnable) &
                       accessLegal(func3, address[1:0], memoryWriteEnable);

  // Store steering uses the live request; load formatting uses the size and
  // lane latched when the access started.
  load_store_aligner u_aligner (
    .i_storeFunc3 (func3),
    .i_storeLane  (address[1:0]),
    .i_storeData  (storeData),
    .o_writeData  (w_alignedWriteData),
    .o_byteEnable (w_alignedByteEnable),
    .i_loadFunc3  (r_func3),
    .i_loadLane   (r_lane),
    .i_readWord   (busReadData),
    .o_loadData   (w_formattedLoad)
  );

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // DONE never looks at the enables: they still belong to the instruction
  // that just finished, so a new request is only recognised back in IDLE.
  always_comb begin
    w_nextState  = r_state;
    w_fsmStall   = 1'b0;
    w_fsmFault   = 1'b0;
    w_busRequest = 1'b0;
    w_start      = 1'b0;
    w_readyHit   = 1'b0;
    w_timeoutHit = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_anyEnable) begin
          if (w_legal) begin
            w_fsmStall  = 1'b1;
            w_start     = 1'b1;
            w_nextState = ST_ACCESS;
          end else begin
            w_fsmFault = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        w_fsmStall   = 1'b1;
        w_busRequest = 1'b1;
        if (busReady) begin
          w_readyHit  = 1'b1;
          w_nextState = ST_DONE;
        end else if (r_waitCount == TIMEOUT_LAST) begin
          w_timeoutHit = 1'b1;
          w_nextState  = ST_DONE;
        end
      end
      ST_DONE: begin
        w_nextState = ST_IDLE;
      end
      default: begin
        w_nextState = ST_IDLE;
      end
    endcase
  end

  // Bus fields are captured once at the start so they stay stable for the
  // whole ACCESS phase; the wait counter counts ACCESS cycles without ready.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_waitCount     <= '0;
      r_func3         <= '0;
      r_lane          <= '0;
      r_busWrite      <= 1'b0;
      r_busAddress    <= '0;
      r_busWriteData  <= '0;
      r_busByteEnable <= '0;
      r_loadData      <= '0;
      r_loadValid     <= 1'b0;
      r_busError      <= 1'b0;
    end else begin
      r_loadValid <= 1'b0;
      r_busError  <= 1'b0;
      if (w_start) begin
        r_waitCount     <= '0;
        r_func3         <= func3;
        r_lane          <= address[1:0];
        r_busWrite      <= memoryWriteEnable;
        r_busAddress    <= {address[31:2], 2'b00};
        r_busWriteData  <= w_alignedWriteData;
        r_busByteEnable <= w_alignedByteEnable;
      end
      if (w_readyHit && !r_busWrite) begin
        r_loadData  <= w_formattedLoad;
        r_loadValid <= 1'b1;
      end
      if (w_timeoutHit) begin
        r_loadData <= '0;
        r_busError <= 1'b1;
      end
      if ((r_state == ST_ACCESS) && !busReady && !w_timeoutHit) begin
        r_waitCount <= r_waitCount + 8'd1;
      end
    end
  end

  // The IDLE request decode is combinational from the inputs, so it is gated
  // with reset to keep the pipeline free while reset is held.
  assign stall         = w_fsmStall & reset;
  assign accessFault   = w_fsmFault & reset;
  assign busRequest    = w_busRequest;
  assign busWrite      = r_busWrite;
  assign busAddress    = r_busAddress;
  assign busWriteData  = r_busWriteData;
  assign busByteEnable = r_busByteEnable;
  assign loadData      = r_loadData;
  assign loadValid     = r_loadValid;
  assign busError      = r_busError;

endmodule

// File: tb/tb_memory_access_unit.sv
// Self-checking bench for memory_access_unit (TIMEOUT_CYCLES = 4).
// A behavioural model derives legality, bus fields and load results from the
// RISC-V load/store rules with plain arithmetic; transactions are directed
// first and then randomized.
module tb_memory_access_unit;

  localparam int TIMEOUT = 4;

  logic        clock;
  logic        reset;
  logic        memoryReadEnable;
  logic        memoryWriteEnable;
  logic [31:0] address;
  logic [31:0] storeData;
  logic [2:0]  func3;
  logic        stall;
  logic [31:0] loadData;
  logic        loadValid;
  logic        accessFault;
  logic        busError;
  logic        busRequest;
  logic        busWrite;
  logic [31:0] busAddress;
  logic [31:0] busWriteData;
  logic [3:0]  busByteEnable;
  logic        busReady;
  logic [31:0] busReadData;

  int          checkCount = 0;
  int          errorCount = 0;
  logic [31:0] modelLoadData = 32'd0;

  memory_access_unit #(.TIMEOUT_CYCLES(TIMEOUT)) dut (
    .clock             (clock),
    .reset             (reset),
    .memoryReadEnable  (memoryReadEnable),
    .memoryWriteEnable (memoryWriteEnable),
    .address           (address),
    .storeData         (storeData),
    .func3             (func3),
    .stall             (stall),
    .loadData          (loadData),
    .loadValid         (loadValid),
    .accessFault       (accessFault),
    .busError          (busError),
    .busRequest        (busRequest),
    .busWrite          (busWrite),
    .busAddress        (busAddress),
    .busWriteData      (busWriteData),
    .busByteEnable     (busByteEnable),
    .busReady          (busReady),
    .busReadData       (busReadData)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Bounds the whole run in case the DUT or bench wedges.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
               tag, observed, expected, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic modelLegal(input logic rd, input logic wr,
                                      input logic [31:0] addr, input logic [2:0] f3);
    int sizeBytes;
    logic sizeOk;
    if (rd && wr) return 1'b0;
    if (wr) sizeOk = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
    else    sizeOk = (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    if (!sizeOk) return 1'b0;
    sizeBytes = 1 << (f3 % 4);
    return ((addr % sizeBytes) == 0);
  endfunction

  function automatic logic [31:0] modelLoad(input logic [2:0] f3, input logic [31:0] addr,
                                            input logic [31:0] word);
    int unsigned lane;
    logic [31:0] b, h;
    lane = addr % 4;
    b = (word >> (8 * lane)) & 32'hFF;
    h = (word >> (16 * (lane / 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd4:    return b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd5:    return h;
      default: return word;
    endcase
  endfunction

  function automatic logic [31:0] modelWriteData(input logic [2:0] f3, input logic [31:0] sd);
    if (f3 == 3'd0) return (sd & 32'hFF) * 32'h0101_0101;
    if (f3 == 3'd1) return (sd & 32'hFFFF) * 32'h0001_0001;
    return sd;
  endfunction

  function automatic logic [31:0] modelEnable(input logic [2:0] f3, input logic [31:0] addr);
    int unsigned lane;
    lane = addr % 4;
    if (f3 == 3'd0) return 32'(1 << lane);
    if (f3 == 3'd1) return (lane < 2) ? 32'h3 : 32'hC;
    return 32'hF;
  endfunction

  // ---------------- stimulus ----------------
  task automatic applyIdle();
    @(posedge clock); #1;
    memoryReadEnable  = 1'b0;
    memoryWriteEnable = 1'b0;
    busReady          = 1'($urandom);
    busReadData       = $urandom;
    @(negedge clock);
    checkOutput("idle_stall", stall, 1'b0);
    checkOutput("idle_req", busRequest, 1'b0);
    checkOutput("idle_fault", accessFault, 1'b0);
    checkOutput("idle_lvalid", loadValid, 1'b0);
    checkOutput("idle_berr", busError, 1'b0);
    checkOutput("idle_ldata", loadData, modelLoadData);
  endtask

  // One memory instruction. waitCycles = ACCESS cycles with busReady low
  // before it goes high; TIMEOUT or more means the access times out.
  // Returns at the negedge of DONE (or of the IDLE cycle after a fault).
  task automatic applyStimulus(input logic rd, input logic wr, input logic [31:0] addr,
                               input logic [31:0] sd, input logic [2:0] f3,
                               input logic [31:0] rdata, input int waitCycles);
    logic legal;
    logic timedOut;
    legal    = modelLegal(rd, wr, addr, f3);
    timedOut = (waitCycles >= TIMEOUT);
    @(posedge clock); #1;
    memoryReadEnable  = rd;
    memoryWriteEnable = wr;
    address           = addr;
    storeData         = sd;
    func3             = f3;
    busReady          = 1'($urandom);
    busReadData       = $urandom;
    @(negedge clock);
    if (!legal) begin
      checkOutput("fault_pulse", accessFault, 1'b1);
      checkOutput("fault_stall", stall, 1'b0);
      checkOutput("fault_req", busRequest, 1'b0);
      @(posedge clock); #1;
      memoryReadEnable  = 1'b0;
      memoryWriteEnable = 1'b0;
      @(negedge clock);
      checkOutput("fault_end", accessFault, 1'b0);
      checkOutput("fault_noreq", busRequest, 1'b0);
      checkOutput("fault_nostall", stall, 1'b0);
      return;
    end
    checkOutput("req_stall", stall, 1'b1);
    checkOutput("req_fault", accessFault, 1'b0);
    checkOutput("req_busreq", busRequest, 1'b0);
    for (int i = 0; i < TIMEOUT; i++) begin
      @(posedge clock); #1;
      busReady    = (i == waitCycles);
      busReadData = (i == waitCycles) ? rdata : $urandom;
      @(negedge clock);
      checkOutput("acc_busreq", busRequest, 1'b1);
      checkOutput("acc_stall", stall, 1'b1);
      checkOutput("acc_write", busWrite, wr);
      checkOutput("acc_addr", busAddress, addr & 32'hFFFF_FFFC);
      if (wr) begin
        checkOutput("acc_wdata", busWriteData, modelWriteData(f3, sd));
        checkOutput("acc_be", {28'd0, busByteEnable}, modelEnable(f3, addr));
      end
      checkOutput("acc_lvalid", loadValid, 1'b0);
      checkOutput("acc_ldata", loadData, modelLoadData);
      if (i == waitCycles) break;
    end
    if (timedOut)  modelLoadData = 32'd0;
    else if (rd)   modelLoadData = modelLoad(f3, addr, rdata);
    @(posedge clock); #1;
    busReady    = 1'($urandom);
    busReadData = $urandom;
    @(negedge clock);
    checkOutput("done_stall", stall, 1'b0);
    checkOutput("done_busreq", busRequest, 1'b0);
    checkOutput("done_lvalid", loadValid, rd && !timedOut);
    checkOutput("done_berr", busError, timedOut);
    checkOutput("done_ldata", loadData, modelLoadData);
  endtask

  // Store abandoned by reset during its second wait cycle.
  task automatic applyResetMidAccess();
    @(posedge clock); #1;
    memoryReadEnable  = 1'b0;
    memoryWriteEnable = 1'b1;
    address           = 32'h300;
    storeData         = 32'hCAFE_F00D;
    func3             = 3'b010;
    busReady          = 1'b0;
    @(posedge clock); #1;
    busReady = 1'b0;
    @(posedge clock); #1;
    busReady = 1'b0;
    @(negedge clock);
    checkOutput("rst_pre_req", busRequest, 1'b1);
    #2;
    reset = 1'b0;
    #1;
    checkOutput("rst_req_drop", busRequest, 1'b0);
    checkOutput("rst_stall_drop", stall, 1'b0);
    checkOutput("rst_write", busWrite, 1'b0);
    checkOutput("rst_addr", busAddress, 32'd0);
    checkOutput("rst_wdata", busWriteData, 32'd0);
    checkOutput("rst_be", {28'd0, busByteEnable}, 32'd0);
    modelLoadData = 32'd0;
    checkOutput("rst_ldata", loadData, modelLoadData);
    @(posedge clock); #1;
    memoryWriteEnable = 1'b0;
    reset = 1'b1;
    @(negedge clock);
    checkOutput("post_rst_stall", stall, 1'b0);
    checkOutput("post_rst_req", busRequest, 1'b0);
    checkOutput("post_rst_lvalid", loadValid, 1'b0);
    checkOutput("post_rst_berr", busError, 1'b0);
    checkOutput("post_rst_addr", busAddress, 32'd0);
  endtask

  initial begin
    reset             = 1'b0;
    memoryReadEnable  = 1'b0;
    memoryWriteEnable = 1'b0;
    address           = 32'd0;
    storeData         = 32'd0;
    func3             = 3'd0;
    busReady          = 1'b0;
    busReadData       = 32'd0;

    // Reset state, with a legal request pending to show stall stays low.
    @(posedge clock); #1;
    memoryReadEnable = 1'b1;
    @(negedge clock);
    checkOutput("reset_stall", stall, 1'b0);
    checkOutput("reset_req", busRequest, 1'b0);
    checkOutput("reset_ldata", loadData, 32'd0);
    checkOutput("reset_lvalid", loadValid, 1'b0);
    checkOutput("reset_berr", busError, 1'b0);
    checkOutput("reset_fault", accessFault, 1'b0);
    checkOutput("reset_write", busWrite, 1'b0);
    checkOutput("reset_addr", busAddress, 32'd0);
    checkOutput("reset_wdata", busWriteData, 32'd0);
    checkOutput("reset_be", {28'd0, busByteEnable}, 32'd0);
    @(posedge clock); #1;
    memoryReadEnable = 1'b0;
    reset = 1'b1;
    applyIdle();

    // Directed cases.
    applyStimulus(1'b1, 1'b0, 32'h100, 32'd0, 3'b010, 32'hDEAD_BEEF, 0);
    checkOutput("lw_const", loadData, 32'hDEAD_BEEF);
    checkOutput("lw_addr", busAddress, 32'h100);
    applyStimulus(1'b1, 1'b0, 32'h103, 32'd0, 3'b000, 32'h80FF_0000, 1);
    checkOutput("lb_const", loadData, 32'hFFFF_FF80);
    applyStimulus(1'b1, 1'b0, 32'h103, 32'd0, 3'b100, 32'h80FF_0000, 0);
    checkOutput("lbu_const", loadData, 32'h0000_0080);
    applyStimulus(1'b1, 1'b0, 32'h102, 32'd0, 3'b001, 32'h80FF_0000, 2);
    checkOutput("lh_const", loadData, 32'hFFFF_80FF);
    applyStimulus(1'b0, 1'b1, 32'h201, 32'h1234_5678, 3'b000, 32'd0, 0);
    checkOutput("sb_addr", busAddress, 32'h200);
    checkOutput("sb_wdata", busWriteData, 32'h7878_7878);
    checkOutput("sb_be", {28'd0, busByteEnable}, 32'h2);
    checkOutput("sb_write", busWrite, 1'b1);
    checkOutput("sb_ldata_kept", loadData, 32'hFFFF_80FF);
    applyStimulus(1'b1, 1'b0, 32'h102, 32'd0, 3'b010, 32'd0, 0);
    applyStimulus(1'b1, 1'b1, 32'h100, 32'd0, 3'b010, 32'd0, 0);
    applyStimulus(1'b0, 1'b1, 32'h100, 32'd0, 3'b100, 32'd0, 0);
    applyStimulus(1'b1, 1'b0, 32'h104, 32'd0, 3'b010, 32'h1111_2222, TIMEOUT);
    checkOutput("timeout_ldata", loadData, 32'd0);
    applyStimulus(1'b1, 1'b0, 32'h108, 32'd0, 3'b101, 32'hABCD_8765, 3);
    applyResetMidAccess();
    applyIdle();

    // Randomized transactions, often back-to-back.
    for (int n = 0; n < 300; n++) begin
      int unsigned kind;
      logic rd, wr;
      logic [2:0] f3;
      logic [2:0] legalSizes [5];
      legalSizes = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
      kind = $urandom_range(0, 9);
      rd = (kind == 1) || (kind >= 2 && kind <= 5);
      wr = (kind == 1) || (kind >= 6);
      if ($urandom_range(0, 9) < 7) f3 = legalSizes[$urandom_range(0, wr ? 2 : 4)];
      else                          f3 = 3'($urandom);
      if (kind == 0) applyIdle();
      else applyStimulus(rd, wr, $urandom, $urandom, f3, $urandom,
                         int'($urandom_range(0, TIMEOUT + 1)));
    end
    applyIdle();

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
